pwm_seq_ctrl: RTL and testbench
===============================

Name: pwm_seq_ctrl

Overview:
Sequencer plus 2-way bus arbiter placed in front of the 6-channel PWM register bus (5-bit address, block select = addr[4:2], 0 = global, 1..6 = PWM0..5). On each overflow event of one selected PWM channel, it writes the next 32-bit word from a local table into a chosen register of that channel. This produces duty/period sweeps without CPU involvement. Host register accesses share the same bus through the arbiter.

Parameters:
TBL_DEPTH, 16, number of table entries
IDX_W, 4, table index width, log2(TBL_DEPTH)

Ports:
mclk  in  1  clock
h_reset_n  in  1  async active-low reset
h_cs  in  1  host request, held until h_ack
h_wr  in  1  host write (1) / read (0)
h_addr  in  5  host address
h_wdata  in  32  host write data
h_be  in  4  host byte enables
h_rdata  out  32  host read data, valid with h_ack
h_ack  out  1  host ack, 1-cycle pulse
m_cs  out  1  master request to PWM bus, held until m_ack
m_wr  out  1  master write
m_addr  out  5  master address
m_wdata  out  32  master write data
m_be  out  4  master byte enables
m_rdata  in  32  PWM bus read data
m_ack  in  1  PWM bus ack
pwm_ovflow  in  6  per-channel period-overflow level/pulse from PWM cores
cfg_seq_enb  in  1  sequencer enable; a rising edge starts a run
cfg_seq_ch  in  3  target channel 0..5; values 6,7 are invalid
cfg_seq_reg  in  2  target register offset inside the channel
cfg_seq_len  in  IDX_W  last table index (entries used = len+1)
cfg_seq_loop  in  1  1 = wrap to index 0 after last entry
tbl_wr  in  1  table write strobe
tbl_idx  in  IDX_W  table write index
tbl_wdata  in  32  table write data
seq_busy  out  1  run active
seq_idx  out  IDX_W  index of the next entry to write
seq_done  out  1  1-cycle pulse at end of a non-loop run

Behaviour:
- Reset: all outputs 0, FSM IDLE, owner NONE, pending tick 0, index 0. Table contents are not reset.
- Tick: rising edge of pwm_ovflow[cfg_seq_ch], detected through a registered previous value. It sets the pending flag.
  - Further ticks while the flag is already set coalesce into one.
  - If cfg_seq_ch > 5, ticks are ignored.
- FSM states: IDLE, WAIT_TICK, REQ, XFER.
  - IDLE -> WAIT_TICK on a cfg_seq_enb rising edge with a valid channel. seq_idx is set to 0, seq_busy to 1, and pending is cleared.
  - WAIT_TICK -> REQ when pending=1. Pending clears on this transition.
  - REQ -> XFER when the arbiter grants SEQ.
  - XFER: drive m_cs=1, m_wr=1, m_be=4'hF, m_addr={cfg_seq_ch+1, cfg_seq_reg}, m_wdata=tbl[seq_idx]. Hold all of these stable until m_ack.
  - On m_ack with seq_idx<len: seq_idx+1, go to WAIT_TICK.
  - On m_ack with seq_idx==len and loop=1: seq_idx=0, go to WAIT_TICK.
  - On m_ack with seq_idx==len and loop=0: pulse seq_done, seq_busy=0, go to IDLE. A new run needs a new enable edge.
- cfg_seq_enb falling:
  - In WAIT_TICK or REQ: go to IDLE immediately, seq_busy=0, no seq_done.
  - In XFER: complete the transaction first, then go to IDLE. m_cs is never dropped before m_ack.
- Config inputs (cfg_seq_ch/reg/len) are sampled on the enable edge and held constant during a run.
- Arbiter:
  - Owner register takes values NONE/HOST/SEQ and changes only when owner is NONE or on m_ack.
  - When owner is NONE, the requesters are h_cs and state==REQ. If both request in the same cycle, SEQ wins.
  - HOST ownership: the m_* outputs follow the h_* inputs combinationally; h_ack=m_ack and h_rdata=m_rdata. The owner returns to NONE on m_ack.
  - While SEQ owns the bus, h_ack=0 and the host waits with h_cs held.
  - No preemption. Bus-idle cycles between back-to-back owners: at least 1, because the owner returns to NONE on m_ack.
- Table write:
  - tbl_wr writes tbl[tbl_idx] in 1 cycle.
  - A write to the entry currently being driven in XFER takes effect after m_ack. Implement this by latching m_wdata on entry to XFER.
  - tbl_idx >= TBL_DEPTH is ignored.

Optional Feature:
PWM_SEQ_OVR_CNT_EN:
- Defined: adds output seq_ovr_cnt[7:0]. This is a saturating count of ticks that arrive while pending=1 or state is REQ/XFER. It clears on the enable rising edge and on reset.
- Undefined: the port and the counter are absent.

Decomposition:
- Package pwm_seq_pkg: FSM state enum (IDLE, WAIT_TICK, REQ, XFER), owner enum (NONE, HOST, SEQ), constant PWM_CH_MAX=5, constant PWM_BLK_BASE=1 (channel-to-block offset).
- Sub-module pwm_seq_tbl: TBL_DEPTH x 32 flop array with one write port and one asynchronous read port.

Test Plan:
- Run without loop: tbl[0..2]=0x10,0x20,0x30, ch=2, reg=1, len=2, loop=0, enable, then 3 overflow pulses on pwm_ovflow[2] -> writes to addr 0x0D with data 0x10, 0x20, 0x30 in order. seq_done pulses once, seq_busy falls, a 4th pulse causes no write.
- Loop wrap: len=1, loop=1, 5 ticks -> data sequence 0x10,0x20,0x10,0x20,0x10. seq_idx ends at 1.
- Simultaneous requests: h_cs and REQ rise in the same cycle, m_ack returned 2 cycles after m_cs -> the SEQ write completes first. The host read of addr 0x04 then completes with h_ack and h_rdata=m_rdata. h_ack stays 0 throughout the SEQ transfer.
- Tick coalescing: 3 ticks while m_ack is stalled 20 cycles -> exactly one further write after the ack. With PWM_SEQ_OVR_CNT_EN, seq_ovr_cnt=3 (first tick counted during XFER).
- Disable mid-transfer: drop cfg_seq_enb during XFER -> m_cs stays high until m_ack, then IDLE, no seq_done. An invalid channel ch=6 with enable -> stays IDLE, no m_cs.
- Async reset during XFER -> m_cs=0 immediately, seq_busy=0, owner NONE. A subsequent run behaves normally.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM register-bus sequencer/arbiter.
package pwm_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      REQ,
      XFER
   } seq_state_t;

   typedef enum logic [1:0] {
      NONE,
      HOST,
      SEQ
   } bus_owner_t;

   localparam int unsigned PWM_CH_MAX   = 5;
   localparam int unsigned PWM_BLK_BASE = 1;

endpackage

// File: rtl/pwm_seq_tbl.sv
// Sequencer word table: flop array, one synchronous write port, one asynchronous read port.
module pwm_seq_tbl #(
   parameter int TBL_DEPTH = 16,
   parameter int IDX_W     = 4
) (
   input  logic             mclk,
   input  logic             i_wr,
   input  logic [IDX_W-1:0] i_widx,
   input  logic [31:0]      i_wdata,
   input  logic [IDX_W-1:0] i_ridx,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [TBL_DEPTH];

   always_ff @(posedge mclk) begin
      if (i_wr && (int'(i_widx) < TBL_DEPTH)) begin
         r_mem[i_widx] <= i_wdata;
      end
   end

   assign o_rdata = (int'(i_ridx) < TBL_DEPTH) ? r_mem[i_ridx] : '0;

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Overflow-driven table sequencer plus 2-way host/sequencer arbiter for the PWM register bus.
// Optional feature macro: PWM_SEQ_OVR_CNT_EN adds the saturating seq_ovr_cnt tick-overrun counter.
module pwm_seq_ctrl
   import pwm_seq_pkg::*;
#(
   parameter int TBL_DEPTH = 16,
   parameter int IDX_W     = 4
) (
   input  logic             mclk,
   input  logic             h_reset_n,
   input  logic             h_cs,
   input  logic             h_wr,
   input  logic [4:0]       h_addr,
   input  logic [31:0]      h_wdata,
   input  logic [3:0]       h_be,
   output logic [31:0]      h_rdata,
   output logic             h_ack,
   output logic             m_cs,
   output logic             m_wr,
   output logic [4:0]       m_addr,
   output logic [31:0]      m_wdata,
   output logic [3:0]       m_be,
   input  logic [31:0]      m_rdata,
   input  logic             m_ack,
   input  logic [5:0]       pwm_ovflow,
   input  logic             cfg_seq_enb,
   input  logic [2:0]       cfg_seq_ch,
   input  logic [1:0]       cfg_seq_reg,
   input  logic [IDX_W-1:0] cfg_seq_len,
   input  logic             cfg_seq_loop,
   input  logic             tbl_wr,
   input  logic [IDX_W-1:0] tbl_idx,
   input  logic [31:0]      tbl_wdata,
   output logic             seq_busy,
   output logic [IDX_W-1:0] seq_idx,
   output logic             seq_done
`ifdef PWM_SEQ_OVR_CNT_EN
   ,
   output logic [7:0]       seq_ovr_cnt
`endif
);

   seq_state_t       r_state;
   bus_owner_t       r_owner;
   logic             r_enb_d;
   logic [5:0]       r_ovf_d;
   logic             r_pend;
   logic             r_busy;
   logic             r_done;
   logic [IDX_W-1:0] r_idx;
   logic [2:0]       r_ch;
   logic [1:0]       r_reg;
   logic [IDX_W-1:0] r_len;
   logic [31:0]      r_wdata;

   logic [31:0]      w_tbl_rdata;
   logic [7:0]       w_ovf_cur;
   logic [7:0]       w_ovf_prev;
   logic [2:0]       w_blk;
   logic             w_enb_rise;
   logic             w_start;
   logic             w_tick;
   logic             w_grant_seq;

   pwm_seq_tbl #(.TBL_DEPTH(TBL_DEPTH), .IDX_W(IDX_W)) u_tbl (
      .mclk    (mclk),
      .i_wr    (tbl_wr),
      .i_widx  (tbl_idx),
      .i_wdata (tbl_wdata),
      .i_ridx  (r_idx),
      .o_rdata (w_tbl_rdata)
   );

   assign w_enb_rise  = cfg_seq_enb & ~r_enb_d;
   assign w_start     = w_enb_rise && (cfg_seq_ch <= 3'(PWM_CH_MAX)) && (r_state == IDLE);
   // Padding to 8 bits lets the 3-bit channel index the vector without a range hole.
   assign w_ovf_cur   = {2'b00, pwm_ovflow};
   assign w_ovf_prev  = {2'b00, r_ovf_d};
   assign w_tick      = (r_state != IDLE) && (r_ch <= 3'(PWM_CH_MAX)) &&
                        w_ovf_cur[r_ch] && !w_ovf_prev[r_ch];
   // Granting only while enabled keeps the bus from being claimed by a run that is being cancelled.
   assign w_grant_seq = (r_owner == NONE) && (r_state == REQ) && cfg_seq_enb;
   assign w_blk       = r_ch + 3'(PWM_BLK_BASE);

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         r_owner <= NONE;
      end else if (r_owner == NONE) begin
         if (w_grant_seq) begin
            r_owner <= SEQ;
         end else if (h_cs) begin
            r_owner <= HOST;
         end
      end else if (m_ack) begin
         r_owner <= NONE;
      end
   end

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         r_state <= IDLE;
         r_enb_d <= 1'b0;
         r_ovf_d <= '0;
         r_pend  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_idx   <= '0;
         r_ch    <= '0;
         r_reg   <= '0;
         r_len   <= '0;
      end else begin
         r_enb_d <= cfg_seq_enb;
         r_ovf_d <= pwm_ovflow;
         r_done  <= 1'b0;
         if (w_start) begin
            r_pend <= 1'b0;
         end else if ((r_state == WAIT_TICK) && r_pend && cfg_seq_enb) begin
            r_pend <= w_tick;
         end else if (w_tick) begin
            r_pend <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state <= WAIT_TICK;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_ch    <= cfg_seq_ch;
                  r_reg   <= cfg_seq_reg;
                  r_len   <= cfg_seq_len;
               end
            end
            WAIT_TICK: begin
               if (!cfg_seq_enb) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (r_pend) begin
                  r_state <= REQ;
               end
            end
            REQ: begin
               if (!cfg_seq_enb) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_grant_seq) begin
                  r_state <= XFER;
               end
            end
            XFER: begin
               if (m_ack) begin
                  if (!cfg_seq_enb) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else if (r_idx != r_len) begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= WAIT_TICK;
                  end else if (cfg_seq_loop) begin
                     r_idx   <= '0;
                     r_state <= WAIT_TICK;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Snapshot the word at grant so table writes during the transfer cannot disturb m_wdata.
   always_ff @(posedge mclk) begin
      if (w_grant_seq) begin
         r_wdata <= w_tbl_rdata;
      end
   end

   always_comb begin
      m_cs    = 1'b0;
      m_wr    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_be    = '0;
      h_ack   = 1'b0;
      h_rdata = '0;
      case (r_owner)
         HOST: begin
            m_cs    = h_cs;
            m_wr    = h_wr;
            m_addr  = h_addr;
            m_wdata = h_wdata;
            m_be    = h_be;
            h_ack   = m_ack;
            h_rdata = m_rdata;
         end
         SEQ: begin
            m_cs    = 1'b1;
            m_wr    = 1'b1;
            m_addr  = {w_blk, r_reg};
            m_wdata = r_wdata;
            m_be    = 4'hF;
         end
         default: ;
      endcase
   end

   assign seq_busy = r_busy;
   assign seq_idx  = r_idx;
   assign seq_done = r_done;

`ifdef PWM_SEQ_OVR_CNT_EN
   logic [7:0] r_ovr_cnt;

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         r_ovr_cnt <= '0;
      end else if (w_enb_rise) begin
         r_ovr_cnt <= '0;
      end else if (w_tick && (r_pend || (r_state == REQ) || (r_state == XFER)) &&
                   (r_ovr_cnt != 8'hFF)) begin
         r_ovr_cnt <= r_ovr_cnt + 8'd1;
      end
   end

   assign seq_ovr_cnt = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Self-checking bench for pwm_seq_ctrl: bus-slave model, write scoreboard, directed and random runs.
`timescale 1ns/1ps
module tb_pwm_seq_ctrl;

   localparam int TBL_DEPTH = 16;
   localparam int IDX_W     = 4;

   logic             mclk = 1'b0;
   logic             h_reset_n = 1'b0;
   logic             h_cs = 1'b0;
   logic             h_wr = 1'b0;
   logic [4:0]       h_addr = '0;
   logic [31:0]      h_wdata = '0;
   logic [3:0]       h_be = '0;
   logic [31:0]      h_rdata;
   logic             h_ack;
   logic             m_cs;
   logic             m_wr;
   logic [4:0]       m_addr;
   logic [31:0]      m_wdata;
   logic [3:0]       m_be;
   logic [31:0]      m_rdata = '0;
   logic             m_ack = 1'b0;
   logic [5:0]       pwm_ovflow = '0;
   logic             cfg_seq_enb = 1'b0;
   logic [2:0]       cfg_seq_ch = '0;
   logic [1:0]       cfg_seq_reg = '0;
   logic [IDX_W-1:0] cfg_seq_len = '0;
   logic             cfg_seq_loop = 1'b0;
   logic             tbl_wr = 1'b0;
   logic [IDX_W-1:0] tbl_idx = '0;
   logic [31:0]      tbl_wdata = '0;
   logic             seq_busy;
   logic [IDX_W-1:0] seq_idx;
   logic             seq_done;
`ifdef PWM_SEQ_OVR_CNT_EN
   logic [7:0]       seq_ovr_cnt;
`endif

   pwm_seq_ctrl #(.TBL_DEPTH(TBL_DEPTH), .IDX_W(IDX_W)) dut (
      .mclk(mclk), .h_reset_n(h_reset_n),
      .h_cs(h_cs), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata), .h_be(h_be),
      .h_rdata(h_rdata), .h_ack(h_ack),
      .m_cs(m_cs), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_rdata(m_rdata), .m_ack(m_ack),
      .pwm_ovflow(pwm_ovflow),
      .cfg_seq_enb(cfg_seq_enb), .cfg_seq_ch(cfg_seq_ch), .cfg_seq_reg(cfg_seq_reg),
      .cfg_seq_len(cfg_seq_len), .cfg_seq_loop(cfg_seq_loop),
      .tbl_wr(tbl_wr), .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata),
      .seq_busy(seq_busy), .seq_idx(seq_idx), .seq_done(seq_done)
`ifdef PWM_SEQ_OVR_CNT_EN
      , .seq_ovr_cnt(seq_ovr_cnt)
`endif
   );

   always #5 mclk = ~mclk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] tb_tbl [TBL_DEPTH];
   int          errors = 0;
   int          checks = 0;
   int          seq_writes = 0;
   int          done_cnt = 0;
   int          lat_min = 0;
   int          lat_max = 3;
   bit          stop_host = 1'b0;

   function automatic logic [31:0] rd_val(input logic [4:0] a);
      return 32'hC0DE_0000 | {27'd0, a};
   endfunction

   function automatic logic [4:0] seq_addr(input int ch, input int rg);
      return 5'(((ch + 1) * 4) + rg);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus slave: acks every request after a random latency, read data derived from address.
   int slv_cnt = -1;
   initial begin
      forever begin
         @(negedge mclk);
         if (!h_reset_n || m_ack) begin
            m_ack   = 1'b0;
            slv_cnt = -1;
         end else if (m_cs) begin
            if (slv_cnt < 0) slv_cnt = lat_min + int'($urandom_range(lat_max - lat_min));
            if (slv_cnt == 0) begin
               m_ack   = 1'b1;
               m_rdata = rd_val(m_addr);
            end else begin
               slv_cnt--;
            end
         end
      end
   end

   // Per-cycle compare process.
   initial begin
      logic        p_cs, p_ack, p_wr, p_done;
      logic [4:0]  p_addr;
      logic [31:0] p_wdata;
      wr_t         e;
      p_cs = 0; p_ack = 0; p_wr = 0; p_done = 0; p_addr = '0; p_wdata = '0;
      forever begin
         @(negedge mclk);
         #2;
         if (!h_reset_n) begin
            p_cs = 0; p_ack = 0; p_done = 0;
            continue;
         end
         if (p_cs && !p_ack) begin
            chk("m_cs_held", 32'(m_cs), 32'd1);
            chk("m_fields_stable", {m_wr, m_addr, 26'd0}, {p_wr, p_addr, 26'd0});
            chk("m_wdata_stable", m_wdata, p_wdata);
         end
         if (m_cs && m_wr) begin
            chk("h_ack_during_seq", 32'(h_ack), 32'd0);
            chk("seq_be", 32'(m_be), 32'hF);
            if (m_ack) begin
               seq_writes++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got addr %h data %h expected none", m_addr, m_wdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("seq_addr", 32'(m_addr), 32'(e.addr));
                  chk("seq_data", m_wdata, e.data);
               end
            end
         end else if (m_cs && !m_wr) begin
            chk("host_ack_follow", 32'(h_ack), 32'(m_ack));
         end
         if (seq_done) begin
            done_cnt++;
            chk("done_single_cycle", 32'(p_done), 32'd0);
         end
         p_cs = m_cs; p_ack = m_ack; p_wr = m_wr; p_addr = m_addr; p_wdata = m_wdata;
         p_done = seq_done;
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic tbl_write(input int i, input logic [31:0] d);
      @(posedge mclk); #1;
      tbl_wr = 1'b1; tbl_idx = IDX_W'(i); tbl_wdata = d;
      tb_tbl[i] = d;
      @(posedge mclk); #1;
      tbl_wr = 1'b0;
   endtask

   task automatic pulse(input logic [5:0] v);
      @(posedge mclk); #1;
      pwm_ovflow = v;
      @(posedge mclk); #1;
      pwm_ovflow = '0;
   endtask

   task automatic start_run(input int ch, input int rg, input int len, input bit lp);
      @(posedge mclk); #1;
      cfg_seq_enb = 1'b0;
      cfg_seq_ch = 3'(ch); cfg_seq_reg = 2'(rg); cfg_seq_len = IDX_W'(len); cfg_seq_loop = lp;
      cyc(1);
      cfg_seq_enb = 1'b1;
      cyc(2);
   endtask

   task automatic wait_writes(input int target);
      int n = 0;
      while (seq_writes < target && n < 400) begin
         @(negedge mclk); #3;
         n++;
      end
      chk("seq_write_seen", 32'(seq_writes >= target), 32'd1);
   endtask

   task automatic wait_mcs();
      int n = 0;
      while (!(m_cs && m_wr) && n < 100) begin
         @(negedge mclk); #3;
         n++;
      end
      chk("seq_xfer_started", 32'(m_cs && m_wr), 32'd1);
   endtask

   // Host read caller must be at posedge+1; h_cs is held until h_ack.
   task automatic host_read(input logic [4:0] a);
      int n = 0;
      h_cs = 1'b1; h_wr = 1'b0; h_addr = a; h_be = 4'hF; h_wdata = $urandom;
      do begin
         @(negedge mclk); #3;
         n++;
      end while (!h_ack && n < 300);
      chk("host_ack_seen", 32'(h_ack), 32'd1);
      if (h_ack) chk("host_rdata", h_rdata, rd_val(a));
      @(posedge mclk); #1;
      h_cs = 1'b0;
   endtask

   task automatic run_random(input bit lp);
      int len, ch, rg, n, w, base, nz;
      len = $urandom_range(5); ch = $urandom_range(5); rg = $urandom_range(3);
      for (int i = 0; i <= len; i++) tbl_write(i, $urandom);
      start_run(ch, rg, len, lp);
      base = done_cnt;
      n = lp ? int'($urandom_range(1, 8)) : len + 1;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{addr: seq_addr(ch, rg), data: tb_tbl[k % (len + 1)]});
         w = seq_writes;
         pulse(6'(1 << ch));
         wait_writes(w + 1);
         repeat (2) @(negedge mclk);
         #3;
         if (lp || k < len) begin
            chk("rnd_seq_idx", 32'(seq_idx), 32'((k + 1) % (len + 1)));
            chk("rnd_busy", 32'(seq_busy), 32'd1);
         end
         nz = (ch + 1 + int'($urandom_range(4))) % 6;
         pulse(6'(1 << nz));
         cyc(4);
         chk("rnd_no_stray_write", 32'(seq_writes), 32'(w + 1));
      end
      if (!lp) begin
         chk("rnd_done", 32'(done_cnt), 32'(base + 1));
         chk("rnd_busy_end", 32'(seq_busy), 32'd0);
         w = seq_writes;
         pulse(6'(1 << ch));
         cyc(8);
         chk("rnd_no_write_after_done", 32'(seq_writes), 32'(w));
      end else begin
         cfg_seq_enb = 1'b0;
         cyc(2);
         chk("rnd_busy_disabled", 32'(seq_busy), 32'd0);
         chk("rnd_no_done_loop", 32'(done_cnt), 32'(base));
      end
      cfg_seq_enb = 1'b0;
      stop_host = 1'b1;
   endtask

   initial begin
      int w, base;
      // Reset state
      cyc(2);
      chk("rst_m_cs", 32'(m_cs), 32'd0);
      chk("rst_h_ack", 32'(h_ack), 32'd0);
      chk("rst_busy", 32'(seq_busy), 32'd0);
      chk("rst_idx", 32'(seq_idx), 32'd0);
      chk("rst_done", 32'(seq_done), 32'd0);
      h_reset_n = 1'b1;
      cyc(2);

      // Single run without loop, channel 2 register 1 -> address 0x0D
      tbl_write(0, 32'h10); tbl_write(1, 32'h20); tbl_write(2, 32'h30);
      start_run(2, 1, 2, 1'b0);
      chk("run_busy", 32'(seq_busy), 32'd1);
      base = done_cnt;
      exp_q.push_back('{addr: 5'h0D, data: 32'h10});
      exp_q.push_back('{addr: 5'h0D, data: 32'h20});
      exp_q.push_back('{addr: 5'h0D, data: 32'h30});
      for (int k = 0; k < 3; k++) begin
         w = seq_writes;
         pulse(6'b000100);
         wait_writes(w + 1);
         cyc(3);
      end
      chk("run_done_once", 32'(done_cnt), 32'(base + 1));
      chk("run_busy_fell", 32'(seq_busy), 32'd0);
      w = seq_writes;
      pulse(6'b000100);
      cyc(8);
      chk("run_4th_no_write", 32'(seq_writes), 32'(w));

      // Loop wrap
      start_run(2, 1, 1, 1'b1);
      exp_q.push_back('{addr: 5'h0D, data: 32'h10});
      exp_q.push_back('{addr: 5'h0D, data: 32'h20});
      exp_q.push_back('{addr: 5'h0D, data: 32'h10});
      exp_q.push_back('{addr: 5'h0D, data: 32'h20});
      exp_q.push_back('{addr: 5'h0D, data: 32'h10});
      for (int k = 0; k < 5; k++) begin
         w = seq_writes;
         pulse(6'b000100);
         wait_writes(w + 1);
         cyc(3);
      end
      chk("loop_idx_end", 32'(seq_idx), 32'd1);
      chk("loop_busy", 32'(seq_busy), 32'd1);
      cfg_seq_enb = 1'b0;
      cyc(2);

      // Simultaneous host and sequencer request: sequencer wins
      lat_min = 2; lat_max = 2;
      start_run(2, 1, 2, 1'b0);
      base = done_cnt;
      exp_q.push_back('{addr: 5'h0D, data: 32'h10});
      w = seq_writes;
      @(posedge mclk); #1; pwm_ovflow = 6'b000100;
      @(posedge mclk); #1; pwm_ovflow = '0;
      @(posedge mclk); #1;
      host_read(5'h04);
      chk("arb_seq_first", 32'(seq_writes), 32'(w + 1));
      cfg_seq_enb = 1'b0;
      cyc(3);

      // Tick coalescing under a stalled ack, with a table rewrite of the entry in flight
      lat_min = 20; lat_max = 20;
      tbl_write(0, 32'h10);
      start_run(2, 1, 0, 1'b1);
      exp_q.push_back('{addr: 5'h0D, data: 32'h10});
      exp_q.push_back('{addr: 5'h0D, data: 32'h55});
      w = seq_writes;
      pulse(6'b000100);
      wait_mcs();
      tbl_write(0, 32'h55);
      for (int k = 0; k < 3; k++) pulse(6'b000100);
      chk("coal_still_stalled", 32'(seq_writes), 32'(w));
      wait_writes(w + 2);
      cyc(40);
      chk("coal_one_extra", 32'(seq_writes), 32'(w + 2));
`ifdef PWM_SEQ_OVR_CNT_EN
      chk("ovr_cnt", 32'(seq_ovr_cnt), 32'd3);
`endif
      cfg_seq_enb = 1'b0;
      cyc(3);

      // Disable during the transfer: completes, then idle without done
      lat_min = 6; lat_max = 6;
      start_run(2, 1, 2, 1'b0);
      base = done_cnt;
      exp_q.push_back('{addr: 5'h0D, data: tb_tbl[0]});
      w = seq_writes;
      pulse(6'b000100);
      wait_mcs();
      @(posedge mclk); #1;
      cfg_seq_enb = 1'b0;
      wait_writes(w + 1);
      cyc(3);
      chk("dis_busy", 32'(seq_busy), 32'd0);
      chk("dis_no_done", 32'(done_cnt), 32'(base));
      pulse(6'b000100);
      cyc(8);
      chk("dis_no_more", 32'(seq_writes), 32'(w + 1));

      // Invalid channel never starts
      start_run(6, 0, 1, 1'b0);
      chk("inv_busy", 32'(seq_busy), 32'd0);
      w = seq_writes;
      pulse(6'h3F);
      cyc(10);
      chk("inv_no_write", 32'(seq_writes), 32'(w));
      chk("inv_no_mcs", 32'(m_cs), 32'd0);
      cfg_seq_enb = 1'b0;

      // Asynchronous reset in the middle of a transfer
      lat_min = 10; lat_max = 10;
      start_run(3, 2, 0, 1'b0);
      exp_q.push_back('{addr: seq_addr(3, 2), data: tb_tbl[0]});
      pulse(6'b001000);
      wait_mcs();
      @(negedge mclk); #1;
      h_reset_n = 1'b0;
      cfg_seq_enb = 1'b0;
      #1;
      chk("arst_m_cs", 32'(m_cs), 32'd0);
      chk("arst_busy", 32'(seq_busy), 32'd0);
      chk("arst_idx", 32'(seq_idx), 32'd0);
      exp_q.delete();
      cyc(2);
      h_reset_n = 1'b1;
      lat_min = 0; lat_max = 3;
      cyc(2);
      host_read(5'h11);

      // Randomized runs with concurrent host reads
      for (int r = 0; r < 8; r++) begin
         stop_host = 1'b0;
         fork
            run_random(r[0]);
            begin
               while (!stop_host) begin
                  @(posedge mclk); #1;
                  if ($urandom_range(5) == 0) host_read(5'($urandom_range(31)));
               end
            end
         join
         cyc(2);
      end
      chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
